// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse at expiry.
// Optional periodic mode selected with `define COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enabled,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap;

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        reload_d = reload_q;
        wrap     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // DONE always falls back to IDLE unless a new delay is accepted.
                if (state_q == DONE) begin
                    state_d = IDLE;
                    value_d = '0;
                end
                if (!abort && start) begin
                    if (load_value != '0) begin
                        state_d  = RUN;
                        value_d  = load_value;
                        reload_d = load_value;
                    end else begin
                        state_d = DONE;
                        value_d = '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    value_d = '0;
                end else if (enabled) begin
                    if (value_q == WIDTH'(1)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        value_d = reload_q;
                        wrap    = 1'b1;
`else
                        value_d = '0;
                        state_d = DONE;
`endif
                    end else if (value_q != '0) begin
                        value_d = value_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                value_d = '0;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE) || wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            value_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign value = value_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a behavioural model.
module tb_countdown_timer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             enabled = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] value;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .load_value(load_value),
        .enabled(enabled), .abort(abort), .busy(busy), .done(done), .value(value)
    );

    always #5 clk = ~clk;

    // Model: "counting" flag, remaining count, pending expiry pulse.
    bit      model_valid = 0;
    bit      m_counting = 0;
    bit      m_pulse = 0;
    int      m_remaining = 0;
    int      m_period = 0;

    always @(posedge clk) begin
        if (reset) begin
            model_valid = 1;
            m_counting  = 0;
            m_pulse     = 0;
            m_remaining = 0;
            m_period    = 0;
        end else if (abort) begin
            if (m_counting || m_pulse) begin
                m_counting  = 0;
                m_pulse     = 0;
                m_remaining = 0;
            end
        end else if (!m_counting && start) begin
            if (load_value != 0) begin
                m_counting  = 1;
                m_pulse     = 0;
                m_remaining = int'(load_value);
                m_period    = int'(load_value);
            end else begin
                m_counting  = 0;
                m_pulse     = 1;
                m_remaining = 0;
            end
        end else if (m_counting) begin
            m_pulse = 0;
            if (enabled) begin
                m_remaining = m_remaining - 1;
                if (m_remaining == 0) begin
                    m_pulse = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    m_remaining = m_period;
`else
                    m_counting = 0;
`endif
                end
            end
        end else begin
            m_pulse     = 0;
            m_remaining = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_busy", 32'(busy), 32'(m_counting));
            chk("model_done", 32'(done), 32'(m_pulse));
            chk("model_value", 32'(value), 32'(m_remaining));
        end
    end

    task automatic step(input bit r, input bit s, input int lv, input bit en, input bit ab);
        @(negedge clk);
        reset      = r;
        start      = s;
        load_value = WIDTH'(lv);
        enabled    = en;
        abort      = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int v, input bit b, input bit d);
        chk({name, "_value"}, 32'(value), 32'(v));
        chk({name, "_busy"}, 32'(busy), 32'(b));
        chk({name, "_done"}, 32'(done), 32'(d));
    endtask

    int cyc;
    int done_seen;

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        expect_out("reset", 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            expect_out("idle", 0, 0, 0);
        end
        $display("reset/idle phase complete");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // L=3 one-shot
        step(0, 1, 3, 1, 0); expect_out("l3_a", 3, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l3_b", 2, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l3_c", 1, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l3_d", 0, 0, 1);
        step(0, 0, 0, 1, 0); expect_out("l3_e", 0, 0, 0);
        $display("txn: start L=3 checked");

        // L=5 with two frozen cycles and ignored restarts
        step(0, 1, 5, 1, 0); expect_out("l5_a", 5, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l5_b", 4, 1, 0);
        step(0, 1, 99, 0, 0); expect_out("l5_hold1", 4, 1, 0);
        step(0, 1, 99, 0, 0); expect_out("l5_hold2", 4, 1, 0);
        step(0, 1, 77, 1, 0); expect_out("l5_c", 3, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l5_d", 2, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l5_e", 1, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l5_f", 0, 0, 1);
        $display("txn: start L=5 with freeze checked");

        // L=0 then back-to-back L=2 accepted in the DONE cycle
        step(0, 1, 0, 1, 0); expect_out("l0_a", 0, 0, 1);
        step(0, 1, 2, 1, 0); expect_out("l0_b", 2, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l0_c", 1, 1, 0);
        step(0, 0, 0, 1, 0); expect_out("l0_d", 0, 0, 1);
        step(0, 0, 0, 1, 0); expect_out("l0_e", 0, 0, 0);
        $display("txn: start L=0 then L=2 checked");

        // abort+start at value 9, then abort in idle
        step(0, 1, 12, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        expect_out("ab_pre", 9, 1, 0);
        step(0, 1, 5, 1, 1); expect_out("ab_a", 0, 0, 0);
        step(0, 0, 0, 1, 1); expect_out("ab_idle", 0, 0, 0);
        step(0, 0, 0, 1, 0); expect_out("ab_after", 0, 0, 0);
        $display("txn: abort checked");

        // reset mid-count at value 7
        step(0, 1, 7, 1, 0); expect_out("rs_pre", 7, 1, 0);
        step(1, 0, 0, 1, 0); expect_out("rs_a", 0, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 0);
            if (done) done_seen++;
        end
        chk("rs_no_done", 32'(done_seen), 32'd0);
        $display("txn: reset mid-count checked");
`else
        step(0, 1, 4, 1, 0); expect_out("ar_a", 4, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 1, 0);
            expect_out("ar_seq", 4 - (k % 4), 1, (k % 4) == 0);
        end
        step(0, 0, 0, 1, 1); expect_out("ar_abort", 0, 0, 0);
        $display("txn: auto-reload L=4 checked");
`endif

        // bounded wait for expiry of L=6
        step(0, 1, 6, 1, 0);
        cyc = 0;
        while (!done && cyc < 20) begin
            step(0, 0, 0, 1, 0);
            cyc++;
        end
        chk("wait_done_seen", 32'(done), 32'd1);
        chk("wait_done_latency", 32'(cyc), 32'd6);
        step(0, 0, 0, 1, 1);
        $display("txn: bounded wait L=6 took %0d cycles", cyc);

        // randomized phase, checked every cycle by the model compare process
        for (int i = 0; i < 3000; i++) begin
            automatic bit r  = ($urandom_range(0, 63) == 0);
            automatic bit ab = ($urandom_range(0, 15) == 0);
            automatic bit s  = ($urandom_range(0, 3) == 0);
            automatic bit en = ($urandom_range(0, 3) != 0);
            automatic int lv = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6))
                                                         : int'($urandom_range(0, 40));
            step(r, s, lv, en, ab);
        end
        $display("random phase complete");

        step(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
